// File: rtl/mem_responder_pkg.sv
// Shared types and default widths for the fixed-latency memory responder.
package mem_responder_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 16;

  // Responder FSM; encodings are fixed so waveforms match the memory stage docs.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } stateT;

  typedef enum logic {
    OpRd = 1'b0,
    OpWr = 1'b1
  } opT;

endpackage

// File: rtl/mem_responder_if.sv
// Request/handshake bus between the pipeline memory stage and the responder.
interface mem_responder_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);

  logic              Rd;
  logic              Wr;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] DataIn;
  logic              createdump;
  logic [DATA_W-1:0] DataOut;
  logic              Done;
  logic              Stall;
  logic              err;

  // Requester side (memory stage).
  modport master (
    output Rd, Wr, Addr, DataIn, createdump,
    input  DataOut, Done, Stall, err
  );

  // Responder side.
  modport slave (
    input  Rd, Wr, Addr, DataIn, createdump,
    output DataOut, Done, Stall, err
  );

endinterface

// File: rtl/mem_responder_array.sv
// Word storage: synchronous single write port, combinational read, no reset.
module mem_responder_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  localparam int unsigned IdxW  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IdxW-1:0]   wIdx,
  input  logic [DATA_W-1:0] wData,
  input  logic [IdxW-1:0]   rIdx,
  output logic [DATA_W-1:0] rData
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Commit a write at the clock edge; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wIdx] <= wData;
    end
  end

  assign rData = mem[rIdx];

endmodule

// File: rtl/mem_responder.sv
// Deterministic multi-cycle memory responder standing in for the cache/memory
// system behind the pipeline memory stage.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 4
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  stateT             stateQ, stateD;
  logic [CntW-1:0]   cntQ, cntD;
  opT                opQ, opD;
  logic [IdxW-1:0]   idxQ, idxD;
  logic [DATA_W-1:0] dataQ, dataD;

  logic              reqAny, reqBad, reqOk;
  logic              memWe;
  logic [DATA_W-1:0] rdData;
  logic              stallC, doneC, errC;
  logic [DATA_W-1:0] dataOutC;

  // Bits with no functional effect: dump strobe and address bits above the index.
  logic unusedBits;
  assign unusedBits = ^{bus.createdump, bus.Addr[ADDR_W-1:IdxW+1]};

  assign reqAny = bus.Rd | bus.Wr;
  assign reqBad = (bus.Rd & bus.Wr) | (reqAny & bus.Addr[0]);
  assign reqOk  = reqAny & ~reqBad;

  mem_responder_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) uArray (
    .clk  (clk),
    .we   (memWe),
    .wIdx (idxQ),
    .wData(dataQ),
    .rIdx (idxQ),
    .rData(rdData)
  );

  // State and latched request; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ <= StIdle;
      cntQ   <= '0;
      opQ    <= OpRd;
      idxQ   <= '0;
      dataQ  <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      opQ    <= opD;
      idxQ   <= idxD;
      dataQ  <= dataD;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    opD      = opQ;
    idxD     = idxQ;
    dataD    = dataQ;
    stallC   = 1'b0;
    doneC    = 1'b0;
    errC     = 1'b0;
    dataOutC = '0;
    memWe    = 1'b0;
    case (stateQ)
      StIdle: begin
        if (reqOk) begin
          opD    = bus.Wr ? OpWr : OpRd;
          idxD   = bus.Addr[IdxW:1];
          dataD  = bus.DataIn;
          cntD   = CntW'(LATENCY - 1);
          stallC = 1'b1;
          stateD = (LATENCY == 1) ? StDone : StBusy;
        end else if (reqBad) begin
          errC = 1'b1;
        end
      end
      StBusy: begin
        stallC = 1'b1;
        cntD   = cntQ - CntW'(1);
        if (cntQ == CntW'(1)) begin
          stateD = StDone;
        end
      end
      StDone: begin
        doneC  = 1'b1;
        stateD = StIdle;
        if (opQ == OpRd) begin
          dataOutC = rdData;
        end else begin
          memWe = 1'b1;
        end
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  // Outputs are forced low while reset is held, even with a request on the bus.
  assign bus.Stall   = stallC & rst;
  assign bus.Done    = doneC & rst;
  assign bus.err     = errC & rst;
  assign bus.DataOut = rst ? dataOutC : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one LATENCY=4 and one LATENCY=1 instance.
module tb_mem_responder;

  logic clk;
  logic rst;

  mem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus4 ();
  mem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();

  mem_responder #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(4)
  ) dut4 (
    .clk(clk),
    .rst(rst),
    .bus(bus4)
  );

  mem_responder #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(1)
  ) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  typedef struct {
    bit          wr;
    logic [15:0] data;
    int          lat;
  } expItem;

  expItem      sb[$];
  logic [15:0] model4 [256];
  logic [15:0] model1 [256];
  int          checks;
  int          failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic driveReq(input bit sel, input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [15:0] data);
    if (sel) begin
      bus1.Rd = rd; bus1.Wr = wr; bus1.Addr = addr; bus1.DataIn = data;
    end else begin
      bus4.Rd = rd; bus4.Wr = wr; bus4.Addr = addr; bus4.DataIn = data;
    end
  endtask

  task automatic sampleOuts(input bit sel, output logic s, output logic d, output logic e,
                            output logic [15:0] q);
    if (sel) begin
      s = bus1.Stall; d = bus1.Done; e = bus1.err; q = bus1.DataOut;
    end else begin
      s = bus4.Stall; d = bus4.Done; e = bus4.err; q = bus4.DataOut;
    end
  endtask

  // One held request from accept to Done; entered and left at posedge+1.
  task automatic access(input bit sel, input bit wr, input logic [15:0] addr,
                        input logic [15:0] data, input int lat, input string tag);
    expItem      e;
    bit          seen;
    logic        s, d, er;
    logic [15:0] q;
    e.wr   = wr;
    e.data = wr ? 16'h0000 : (sel ? model1[addr[8:1]] : model4[addr[8:1]]);
    e.lat  = lat;
    sb.push_back(e);
    driveReq(sel, !wr, wr, addr, data);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      #4;
      sampleOuts(sel, s, d, er, q);
      if (d) begin
        seen = 1;
        e = sb.pop_front();
        checkVal({tag, " latency"}, k, e.lat);
        checkVal({tag, " data"}, q, e.data);
        checkVal({tag, " stall at done"}, s, 0);
        checkVal({tag, " err at done"}, er, 0);
      end else begin
        checkVal({tag, " stall"}, s, 1);
        checkVal({tag, " err"}, er, 0);
      end
      @(posedge clk); #1;
    end
    if (!seen) begin
      checkVal({tag, " done timeout"}, 0, 1);
      void'(sb.pop_back());
    end
    if (wr) begin
      if (sel) model1[addr[8:1]] = data;
      else model4[addr[8:1]] = data;
    end
    driveReq(sel, 0, 0, 16'h0000, 16'h0000);
  endtask

  // Hold a bad request; expect err every cycle and no stall/done.
  task automatic badReq(input bit rd, input bit wr, input logic [15:0] addr, input string tag);
    logic        s, d, er;
    logic [15:0] q;
    driveReq(0, rd, wr, addr, 16'hFFFF);
    for (int k = 0; k < 2; k++) begin
      #4;
      sampleOuts(0, s, d, er, q);
      checkVal({tag, " err"}, er, 1);
      checkVal({tag, " stall"}, s, 0);
      checkVal({tag, " done"}, d, 0);
      @(posedge clk); #1;
    end
    driveReq(0, 0, 0, 16'h0000, 16'h0000);
    #4;
    sampleOuts(0, s, d, er, q);
    checkVal({tag, " done after"}, d, 0);
    checkVal({tag, " err after"}, er, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic        s, d, er;
    logic [15:0] q;
    expItem      e;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bus4.createdump = 1'b0;
    bus1.createdump = 1'b0;
    driveReq(0, 0, 0, 16'h0000, 16'h0000);
    driveReq(1, 0, 0, 16'h0000, 16'h0000);

    // Reset values.
    @(posedge clk); #1; #4;
    sampleOuts(0, s, d, er, q);
    checkVal("reset stall", s, 0);
    checkVal("reset done", d, 0);
    checkVal("reset err", er, 0);
    checkVal("reset dataout", q, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Write then read back.
    access(0, 1, 16'h0010, 16'hBEEF, 4, "wr 0010");
    access(0, 0, 16'h0010, 16'h0000, 4, "rd 0010");

    // Misaligned read.
    badReq(1, 0, 16'h0011, "misaligned");
    access(0, 0, 16'h0010, 16'h0000, 4, "rd after misaligned");

    // Illegal Rd=Wr=1 must not touch the array.
    access(0, 1, 16'h0020, 16'h1111, 4, "wr 0020");
    badReq(1, 1, 16'h0020, "illegal op");
    access(0, 0, 16'h0020, 16'h0000, 4, "rd 0020");

    // Word index wraps modulo DEPTH.
    access(0, 1, 16'h0002, 16'h1234, 4, "wr 0002");
    access(0, 0, 16'h0202, 16'h0000, 4, "rd wrap 0202");

    // Reset during the second BUSY cycle drops the write.
    access(0, 1, 16'h0040, 16'h5A5A, 4, "wr 0040 old");
    driveReq(0, 0, 1, 16'h0040, 16'hAAAA);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst = 1'b0;
    #1;
    sampleOuts(0, s, d, er, q);
    checkVal("midreset stall", s, 0);
    checkVal("midreset done", d, 0);
    checkVal("midreset err", er, 0);
    checkVal("midreset dataout", q, 0);
    @(posedge clk); #1;
    driveReq(0, 0, 0, 16'h0000, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #4;
      sampleOuts(0, s, d, er, q);
      checkVal("post reset no done", d, 0);
      @(posedge clk); #1;
    end
    access(0, 0, 16'h0040, 16'h0000, 4, "rd 0040 after reset");

    // LATENCY=1: single access, then two reads held back to back.
    access(1, 1, 16'h0030, 16'hC0DE, 1, "l1 wr 0030");
    access(1, 0, 16'h0030, 16'h0000, 1, "l1 rd 0030");
    e.wr = 0; e.data = model1[8'h18]; e.lat = 1;
    sb.push_back(e);
    sb.push_back(e);
    driveReq(1, 1, 0, 16'h0030, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      #4;
      sampleOuts(1, s, d, er, q);
      checkVal("b2b stall", s, (k % 2 == 0) ? 1 : 0);
      checkVal("b2b done", d, (k % 2 == 1) ? 1 : 0);
      if (d) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkVal("b2b data", q, e.data);
        end else begin
          checkVal("b2b extra done", 1, 0);
        end
      end
      @(posedge clk); #1;
    end
    driveReq(1, 0, 0, 16'h0000, 16'h0000);
    checkVal("scoreboard empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the data-memory request/handshake protocol driven by the pipeline memory stage: Rd/Wr, Addr, DataIn in; DataOut, Done, Stall, err out.
- Models a multi-cycle word-addressed memory with fixed access latency.
- Sits behind the memory stage in place of the cache/memory system, so stall-handling logic is exercised against a deterministic responder.
- Storage is an internal array of 16-bit words.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, byte-address width.
- DEPTH, 256, number of words; power of two.
- LATENCY, 4, cycles from request acceptance to Done; minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- Addr  in  ADDR_W  byte address; bit 0 must be 0.
- DataIn  in  DATA_W  write data.
- Rd  in  1  read request, held by requester until Done.
- Wr  in  1  write request, held by requester until Done.
- createdump  in  1  simulation-only dump request; no RTL state effect.
- DataOut  out  DATA_W  read data, valid only while Done=1 for a read.
- Done  out  1  one-cycle completion pulse.
- Stall  out  1  requester must hold the request and freeze.
- err  out  1  one-cycle error pulse.

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, latched op/addr/data cleared; DataOut=0, Done=0, Stall=0, err=0. Array contents are not cleared.
- Reset asserted mid-access: the access is abandoned, a pending write is discarded, and no Done is issued.
- States: IDLE, BUSY, DONE.
- IDLE, valid request (exactly one of Rd/Wr set and Addr[0]=0):
  - Latch op, word index Addr[log2(DEPTH):1], and DataIn.
  - Load counter with LATENCY-1.
  - Stall=1 combinationally in the accept cycle.
  - Next state BUSY, or DONE if LATENCY=1.
- IDLE, Rd=Wr=1, or (Rd|Wr) with Addr[0]=1:
  - err=1 for that cycle; no access, no Done, Stall=0; stay IDLE.
  - Requester holding the bad request causes err every cycle.
- IDLE, Rd=Wr=0: all outputs 0.
- BUSY:
  - Stall=1, counter decrements each cycle.
  - When counter reaches 1, next state is DONE.
  - Input changes during BUSY are ignored; latched values are used.
- DONE, one cycle:
  - Done=1, Stall=0.
  - Read: DataOut = array[latched index].
  - Write: array[latched index] <= latched data at the clock edge ending DONE; DataOut=0.
  - Next state IDLE. A request present in DONE is not accepted.
- Request-to-Done latency: LATENCY cycles after the accept edge, i.e. the accept cycle plus LATENCY-1 BUSY cycles then DONE. Back-to-back throughput: one access per LATENCY+1 cycles.
- Address wrap: word index is taken modulo DEPTH; address bits above the index are ignored.
- Read-after-write to the same address in consecutive accesses returns the new data, because the write commits before the next accept.
- Done and err are never asserted together; Stall and Done are never asserted together.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - op encoding: OP_RD, OP_WR;
  - default widths DATA_W=16, ADDR_W=16.
- One natural sub-module: mem_responder_array, a synchronous-write, combinational-read DEPTH x DATA_W storage with a single write port. It makes the storage swappable for a banked version later.

Test Plan:
- Write/read, LATENCY=4: Wr, Addr=0x0010, DataIn=0xBEEF held.
  - Expect Stall=1 for 4 cycles, then Done=1 for 1 cycle.
  - Then Rd, Addr=0x0010: Done with DataOut=0xBEEF exactly 4 cycles after accept.
- Misaligned access: Rd, Addr=0x0011.
  - Expect err=1 in the same cycle, Stall=0, no Done, state stays IDLE.
- Illegal op: Rd=Wr=1, Addr=0x0020.
  - Expect err=1 and no array change; a later read of 0x0020 returns its prior value.
- Wrap, DEPTH=256: write 0x1234 to Addr=0x0002, then read Addr=0x0202.
  - Expect DataOut=0x1234.
- Reset mid-write: Wr to 0x0040 with 0xAAAA, rst=0 during the second BUSY cycle.
  - Expect all outputs 0 immediately.
  - After release, reading 0x0040 returns its old value (0x0000 if preloaded to 0).
- LATENCY=1 and back-to-back: two reads held consecutively.
  - Expect Done in the cycle after each accept.
  - Expect the second accept only in the cycle after DONE: accept, DONE, accept, DONE.
